csa_frame_accumulator: RTL and testbench
========================================

# csa_frame_accumulator

Accumulates a frame of signed input terms in redundant carry-save form (sum and carry vectors) using a single 3:2 compressor row, with no carry propagation inside the loop. At the end of each frame it presents the final sum/carry pair to the downstream carry-propagate adder stage on a valid/ready handshake. The downstream stage resolves the pair with `a + b` into the `BITS`-wide result. A one-deep output buffer lets the next frame start accumulating while the previous pair waits.

## Interface
- `BITS`, 40: accumulator, sum and carry width; matches the downstream adder width.
- `IN_BITS`, 32: signed input term width; must be ≤ `BITS`.
- `CNT_BITS`, 8: term-counter width; used only with `CSA_ACC_CNT_EN`.

- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: term present.
- `in_ready` output 1: block accepts a term this cycle.
- `in_data` input `IN_BITS`: signed two's-complement term.
- `in_last` input 1: the term is the last of its frame.
- `out_valid` output 1: `sum_out`/`carry_out` hold a completed frame.
- `out_ready` input 1: downstream consumes the pair.
- `sum_out` output `BITS`: sum vector, drives adder operand `a`.
- `carry_out` output `BITS`: carry vector, already weighted by shift, drives adder operand `b`.
- `term_cnt` output `CNT_BITS`: number of terms in the frame on the output. Present only with `CSA_ACC_CNT_EN`.

## Operation
- Term accepted when `in_valid && in_ready`.
- The term is sign-extended to `BITS` as `t`.
- Compress step: `s' = acc_s ^ acc_c ^ t`; `c' = (maj(acc_s, acc_c, t) << 1)`, truncated to `BITS`.
- Invariant: `acc_s + acc_c` (mod 2^BITS) equals the sum of accepted terms in the frame (mod 2^BITS). Overflow wraps silently.
- FSM states: `IDLE`, `ACC`, `HOLD`. Accumulator is zero in `IDLE`.
  - `IDLE`/`ACC`, accepted non-last term: the accumulator takes `s'`/`c'`; next state is `ACC`.
  - `IDLE`/`ACC`, accepted last term, with the output slot free (`!out_valid` or `out_ready` this cycle):
    - Output registers load `s'`/`c'` and `out_valid` is set.
    - Accumulator clears; next state is `IDLE`.
  - `IDLE`/`ACC`, accepted last term, with the output slot occupied and not draining:
    - Accumulator takes `s'`/`c'`; next state is `HOLD`.
  - `HOLD`: `in_ready = 0`.
    - When `out_valid && out_ready`, the output registers load the accumulator and `out_valid` stays 1.
    - Accumulator clears; next state is `IDLE`.
- `in_ready = (state != HOLD)`. It does not depend on `in_valid`.
- `out_valid` clears on `out_valid && out_ready` unless a new pair loads the same edge. Load wins.
- Output registers are stable while `out_valid && !out_ready`.
- A single-term frame (`in_last` on the first term) is legal: the output is `t`/0.
- `in_last` is ignored unless the term is accepted.

## Timing
- Reset values: `out_valid` 0, `sum_out` 0, `carry_out` 0, `term_cnt` 0, accumulator 0, state `IDLE`, `in_ready` 1.
- Reset asserted mid-frame discards the partial accumulator and any pending output, with no handshake.
- Throughput: one term per cycle while not in `HOLD`.
- Latency, last term to output: last term accepted at edge k gives `out_valid` = 1 after edge k (one cycle).
- From `HOLD`, the new pair is visible the cycle after the draining handshake. Back-to-back pairs can be emitted on consecutive cycles.
- The pair is consumed combinationally downstream; this block adds no output skid.

## Configuration
- `CSA_ACC_CNT_EN` defined:
  - An internal counter of accepted terms per frame runs, wrapping at 2^`CNT_BITS`.
  - It loads into `term_cnt` together with `sum_out`/`carry_out`, including the last term.
  - It follows the accumulator through `HOLD`.
- `CSA_ACC_CNT_EN` undefined: the `term_cnt` port, the counter and the `CNT_BITS` logic are absent. All other behaviour is identical.

## Test plan
- Reset, then one frame of terms 5, −3, 10 (`in_last` on 10) with `out_ready` = 1:
  - `out_valid` pulses one cycle after the third accept.
  - `sum_out + carry_out` = 12 (mod 2^40).
  - `term_cnt` = 3 with the macro defined.
- Single-term frame of −1: `sum_out` = 0xFF_FFFF_FFFF, `carry_out` = 0, `term_cnt` = 1.
- Back-pressure:
  - Frame A = {1, 2} completes, then `out_ready` = 0 while frame B = {7, 8} streams.
  - `in_ready` drops after B's last accept (`HOLD`) and the A pair stays stable.
  - Raise `out_ready`: the A pair (sum 3) is consumed, then the B pair (sum 15) appears the next cycle and `in_ready` returns to 1.
- Wrap: two terms of 0x7FFF_FFFF with `IN_BITS` = 32, `BITS` = 40 give 0x00_FFFF_FFFE.
  - 32 frames of terms 0x4000_0000 ×8 give the result 2^33 with no corruption.
- Reset asserted during `ACC` after two terms, and separately while in `HOLD`:
  - All outputs return to their reset values within the reset cycle.
  - The next frame {4} yields exactly 4.
- Random streams of 1–300 terms with random `in_valid`/`out_ready`: the resolved sum matches the model sum mod 2^40. With the macro defined, `term_cnt` matches the frame length mod 256.

Source files
------------

// File: rtl/csa_frame_accumulator.sv
// csa_frame_accumulator
//   Accumulates a frame of signed terms in carry-save form (sum + carry
//   vectors) through one 3:2 compressor row, so there is no carry chain in
//   the loop. At frame end the sum/carry pair is offered to a downstream
//   carry-propagate adder on a valid/ready handshake. A one-deep output
//   register lets the next frame accumulate while the previous pair waits.
//
//   Parameters:
//     BITS     accumulator / sum / carry width
//     IN_BITS  signed input term width (must be <= BITS)
//     CNT_BITS term counter width (only with CSA_ACC_CNT_EN)
//
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     in_valid/in_ready term handshake; in_ready low only while holding a
//                       completed frame behind an occupied output slot
//     in_data, in_last  signed term, last-term-of-frame flag
//     out_valid/out_ready output pair handshake
//     sum_out, carry_out  sum vector (operand a), shifted carry vector (b)
//     term_cnt          terms in the frame on the output (CSA_ACC_CNT_EN)
//
//   Optional feature macro: CSA_ACC_CNT_EN enables the per-frame term counter.
module csa_frame_accumulator #(
  parameter int BITS    = 40,
  parameter int IN_BITS = 32
`ifdef CSA_ACC_CNT_EN
  , parameter int CNT_BITS = 8
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_BITS-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BITS-1:0]    sum_out,
  output logic [BITS-1:0]    carry_out
`ifdef CSA_ACC_CNT_EN
  , output logic [CNT_BITS-1:0] term_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] acc_s_q, acc_s_d, acc_c_q, acc_c_d;
  logic [BITS-1:0] out_s_q, out_s_d, out_c_q, out_c_d;
  logic            out_v_q, out_v_d;
  logic [BITS-1:0] t, s_n, maj, c_n;
  logic            accept, drain, slot_free;
`ifdef CSA_ACC_CNT_EN
  logic [CNT_BITS-1:0] cnt_q, cnt_d, ocnt_q, ocnt_d, cnt_n;
`endif

  assign t   = BITS'($signed(in_data));
  assign s_n = acc_s_q ^ acc_c_q ^ t;
  assign maj = (acc_s_q & acc_c_q) | (acc_s_q & t) | (acc_c_q & t);
  assign c_n = {maj[BITS-2:0], 1'b0};

  assign in_ready  = (state_q != HOLD);
  assign accept    = in_valid && in_ready;
  assign drain     = out_v_q && out_ready;
  assign slot_free = !out_v_q || out_ready;

  assign out_valid = out_v_q;
  assign sum_out   = out_s_q;
  assign carry_out = out_c_q;
`ifdef CSA_ACC_CNT_EN
  assign cnt_n    = cnt_q + CNT_BITS'(1);
  assign term_cnt = ocnt_q;
`endif

  always_comb begin
    state_d = state_q;
    acc_s_d = acc_s_q;
    acc_c_d = acc_c_q;
    out_s_d = out_s_q;
    out_c_d = out_c_q;
    // a load in the same cycle as a drain overrides the clear below
    out_v_d = out_v_q && !drain;
`ifdef CSA_ACC_CNT_EN
    cnt_d  = cnt_q;
    ocnt_d = ocnt_q;
`endif
    case (state_q)
      IDLE, ACC: begin
        if (accept) begin
          if (in_last && slot_free) begin
            out_s_d = s_n;
            out_c_d = c_n;
            out_v_d = 1'b1;
            acc_s_d = '0;
            acc_c_d = '0;
            state_d = IDLE;
`ifdef CSA_ACC_CNT_EN
            ocnt_d = cnt_n;
            cnt_d  = '0;
`endif
          end else begin
            acc_s_d = s_n;
            acc_c_d = c_n;
            state_d = in_last ? HOLD : ACC;
`ifdef CSA_ACC_CNT_EN
            cnt_d = cnt_n;
`endif
          end
        end
      end
      HOLD: begin
        if (drain) begin
          out_s_d = acc_s_q;
          out_c_d = acc_c_q;
          out_v_d = 1'b1;
          acc_s_d = '0;
          acc_c_d = '0;
          state_d = IDLE;
`ifdef CSA_ACC_CNT_EN
          ocnt_d = cnt_q;
          cnt_d  = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_s_q <= '0;
      acc_c_q <= '0;
      out_s_q <= '0;
      out_c_q <= '0;
      out_v_q <= 1'b0;
`ifdef CSA_ACC_CNT_EN
      cnt_q  <= '0;
      ocnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_s_q <= acc_s_d;
      acc_c_q <= acc_c_d;
      out_s_q <= out_s_d;
      out_c_q <= out_c_d;
      out_v_q <= out_v_d;
`ifdef CSA_ACC_CNT_EN
      cnt_q  <= cnt_d;
      ocnt_q <= ocnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_csa_frame_accumulator.sv
module tb_csa_frame_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [39:0] sum_out, carry_out;
`ifdef CSA_ACC_CNT_EN
  logic [7:0]  term_cnt;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  csa_frame_accumulator #(
    .BITS(40),
    .IN_BITS(32)
`ifdef CSA_ACC_CNT_EN
    , .CNT_BITS(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .carry_out(carry_out)
`ifdef CSA_ACC_CNT_EN
    , .term_cnt(term_cnt)
`endif
  );

  function automatic logic [39:0] resolved();
    return sum_out + carry_out;
  endfunction

  function automatic logic [39:0] sext(input logic [31:0] d);
    return {{8{d[31]}}, d};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm, input int unsigned exp);
`ifdef CSA_ACC_CNT_EN
    chk(nm, 64'(term_cnt), 64'(exp % 256));
`else
    if (exp == 32'hFFFF_FFFF) $display("unused %s", nm);
`endif
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one term and hold it until accepted (bounded)
  task automatic send(input logic [31:0] d, input bit last);
    int unsigned w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && w < 100) begin
      step();
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_ovalid"}, 64'(out_valid), 64'd0);
    chk({nm, "_sum"}, 64'(sum_out), 64'd0);
    chk({nm, "_carry"}, 64'(carry_out), 64'd0);
    chk({nm, "_iready"}, 64'(in_ready), 64'd1);
    chk_cnt({nm, "_cnt"}, 0);
  endtask

  typedef struct packed {
    logic [2:0]       n;
    logic [3:0][31:0] t;
    logic [39:0]      exp_res;
  } vec_t;

  vec_t vecs[6];

  logic [31:0] flat_d[$];
  bit          flat_last[$];
  logic [39:0] exp_q[$];
  int unsigned len_q[$];

  initial begin
    vecs[0] = '{n: 3'd3, t: {32'd0, 32'd10, 32'hFFFF_FFFD, 32'd5}, exp_res: 40'd12};
    vecs[1] = '{n: 3'd1, t: {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF}, exp_res: 40'hFF_FFFF_FFFF};
    vecs[2] = '{n: 3'd2, t: {32'd0, 32'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF}, exp_res: 40'h00_FFFF_FFFE};
    vecs[3] = '{n: 3'd1, t: {32'd0, 32'd0, 32'd0, 32'h8000_0000}, exp_res: 40'hFF_8000_0000};
    vecs[4] = '{n: 3'd4, t: {32'hFFFF_FFF0, 32'd100, 32'hFFFF_FF9C, 32'd3}, exp_res: 40'hFF_FFFF_FFF3};
    vecs[5] = '{n: 3'd1, t: {32'd0, 32'd0, 32'd0, 32'd4}, exp_res: 40'd4};

    // reset state, checked while reset is held
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    step();

    // table-driven frames with out_ready held high
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        send(vecs[v].t[i], (i == int'(vecs[v].n) - 1));
        if (i != int'(vecs[v].n) - 1) chk($sformatf("v%0d_novalid_%0d", v, i), 64'(out_valid), 64'd0);
      end
      chk($sformatf("v%0d_valid", v), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d_res", v), 64'(resolved()), 64'(vecs[v].exp_res));
      chk_cnt($sformatf("v%0d_cnt", v), int'(vecs[v].n));
      if (vecs[v].n == 3'd1) begin
        chk($sformatf("v%0d_sum", v), 64'(sum_out), 64'(sext(vecs[v].t[0])));
        chk($sformatf("v%0d_carry", v), 64'(carry_out), 64'd0);
      end
      step();
      chk($sformatf("v%0d_pulse_end", v), 64'(out_valid), 64'd0);
    end

    // 32 frames of 8 x 2^30
    for (int f = 0; f < 32; f++) begin
      for (int i = 0; i < 8; i++) send(32'h4000_0000, (i == 7));
      chk($sformatf("wrap_f%0d_res", f), 64'(resolved()), 64'h2_0000_0000);
      chk_cnt($sformatf("wrap_f%0d_cnt", f), 8);
    end
    step();

    // back-pressure: A={1,2} waits, B={7,8} reaches HOLD
    send(32'd1, 1'b0);
    send(32'd2, 1'b1);
    out_ready = 1'b0;
    chk("bp_a_valid", 64'(out_valid), 64'd1);
    send(32'd7, 1'b0);
    send(32'd8, 1'b1);
    chk("bp_hold_iready", 64'(in_ready), 64'd0);
    chk("bp_a_res", 64'(resolved()), 64'd3);
    begin
      logic [39:0] s0, c0;
      s0 = sum_out;
      c0 = carry_out;
      repeat (3) step();
      chk("bp_a_sum_stable", 64'(sum_out), 64'(s0));
      chk("bp_a_carry_stable", 64'(carry_out), 64'(c0));
      chk("bp_hold_iready2", 64'(in_ready), 64'd0);
      chk("bp_a_valid2", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    step();
    chk("bp_b_valid", 64'(out_valid), 64'd1);
    chk("bp_b_res", 64'(resolved()), 64'd15);
    chk("bp_b_iready", 64'(in_ready), 64'd1);
    chk_cnt("bp_b_cnt", 2);
    step();
    chk("bp_b_drained", 64'(out_valid), 64'd0);

    // reset during ACC after two terms
    send(32'd9, 1'b0);
    send(32'd11, 1'b0);
    #2 rst = 1'b1;
    #2 chk_reset_vals("rst_acc");
    @(posedge clk);
    #1 rst = 1'b0;
    send(32'd4, 1'b1);
    chk("rst_acc_sum", 64'(sum_out), 64'd4);
    chk("rst_acc_carry", 64'(carry_out), 64'd0);
    chk_cnt("rst_acc_cnt", 1);
    step();

    // reset while in HOLD with a pending pair
    send(32'd6, 1'b1);
    out_ready = 1'b0;
    send(32'd3, 1'b1);
    chk("rst_hold_pre", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #2 chk_reset_vals("rst_hold");
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    send(32'd4, 1'b1);
    chk("rst_hold_sum", 64'(sum_out), 64'd4);
    chk("rst_hold_carry", 64'(carry_out), 64'd0);
    chk_cnt("rst_hold_cnt", 1);
    step();

    // random frames against an arithmetic reference model
    for (int f = 0; f < 6; f++) begin
      int unsigned len;
      logic [39:0] acc;
      len = (f == 0) ? 300 : (f == 1) ? 1 : $urandom_range(1, 300);
      acc = '0;
      for (int unsigned i = 0; i < len; i++) begin
        logic [31:0] d;
        d = $urandom;
        flat_d.push_back(d);
        flat_last.push_back(i == len - 1);
        acc = acc + sext(d);
      end
      exp_q.push_back(acc);
      len_q.push_back(len);
    end
    begin
      int unsigned idx = 0;
      int unsigned cyc = 0;
      int unsigned nfr = 0;
      bit prev_hold = 1'b0;
      logic [39:0] ps, pc;
      while ((exp_q.size() != 0) && cyc < 20000) begin
        bit iv, acc_now, dr;
        if (prev_hold) begin
          chk("rnd_hold_sum", 64'(sum_out), 64'(ps));
          chk("rnd_hold_carry", 64'(carry_out), 64'(pc));
        end
        iv = (idx < flat_d.size()) && ($urandom_range(0, 3) != 0);
        in_valid  = iv;
        in_data   = iv ? flat_d[idx] : $urandom;
        in_last   = iv ? flat_last[idx] : 1'($urandom);
        out_ready = 1'($urandom);
        acc_now = iv && in_ready;
        dr = out_valid && out_ready;
        if (dr) begin
          chk($sformatf("rnd_f%0d_res", nfr), 64'(resolved()), 64'(exp_q.pop_front()));
          chk_cnt($sformatf("rnd_f%0d_cnt", nfr), len_q.pop_front());
          nfr++;
        end
        prev_hold = out_valid && !out_ready;
        ps = sum_out;
        pc = carry_out;
        if (acc_now) idx++;
        step();
        cyc++;
      end
      if (exp_q.size() != 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rnd_timeout: frames left %0d expected 0", exp_q.size());
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
